fpu_mul_serdes: RTL and testbench
=================================

# fpu_mul_serdes

Bit-serial front/back end for the combinational single-precision FP multiplier in the SERV FPU extension. It collects the two operands LSB-first from the core's serial datapath and presents them as parallel words to the multiplier. It captures the product, overrides it for IEEE special cases the multiplier does not handle, and shifts the result back out LSB-first for writeback.

## Interface
Parameters: none; operand width is fixed at 32 (binary32).

Reset: one clock; reset is asynchronous and active-low.

- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  start strobe; accepted only in IDLE; bit 0 of both operands is valid in the same cycle
- i_flush  input  1  synchronous abort to IDLE
- i_rs1  input  1  operand A serial bit, LSB first
- i_rs2  input  1  operand B serial bit, LSB first
- o_mul_a  output  32  operand A to the multiplier
- o_mul_b  output  32  operand B to the multiplier
- i_mul_res  input  32  multiplier product, combinational from o_mul_a/o_mul_b
- o_rd  output  1  result serial bit, LSB first
- o_rd_valid  output  1  high while o_rd carries a result bit
- o_nv  output  1  invalid-operation flag for the last result
- o_busy  output  1  high in any state other than IDLE
- o_done  output  1  one-cycle pulse coinciding with result bit 31

## Operation
- FSM states: IDLE, LOAD, CALC, SHIFT. A 5-bit counter cnt tracks bit position.
- IDLE, i_start=1 and i_flush=0:
  - shift in bit 0 of each operand.
  - cnt <= 1; go to LOAD.
- LOAD: every cycle, opA <= {i_rs1, opA[31:1]} and opB <= {i_rs2, opB[31:1]}; cnt++. After the bit with cnt==31 is taken, go to CALC.
- o_mul_a = opA and o_mul_b = opB at all times. They are meaningful only in CALC.
- CALC (one cycle): res <= special-case result, else i_mul_res. cnt <= 0; go to SHIFT.
- Special cases. Classify each operand as NaN, Inf, zero or finite. A denormal counts as finite and passes to the multiplier.
  - NaN: exp==8'hFF, mant!=0. It is sNaN if mant[22]==0.
  - Inf: exp==8'hFF, mant==0.
  - Zero: exp==0, mant==0.
- Override priority, with s = a[31]^b[31]:
  1. Either operand NaN: res = 32'h7FC00000; nv = 1 if either operand is sNaN.
  2. Inf × zero: res = 32'h7FC00000; nv = 1.
  3. Inf × (Inf or finite): res = {s, 8'hFF, 23'b0}.
  4. Zero × (zero or finite): res = {s, 31'b0}.
  5. Otherwise: res = i_mul_res; nv = 0.
- SHIFT: o_rd = res[0], o_rd_valid = 1; res <= res >> 1; cnt++. When cnt==31, assert o_done and go to IDLE next cycle.
- o_rd = 0 and o_rd_valid = 0 outside SHIFT.
- o_nv is registered in CALC and holds until the next CALC, flush or reset.
- i_start is ignored while busy, including when it is held high.
- i_flush in any state: next state IDLE, cnt <= 0, o_nv <= 0, no o_done. opA, opB and res are left as is.
- i_flush wins over a simultaneous i_start in IDLE.

## Timing
- Reset (async, immediate):
  - state IDLE, cnt 0.
  - opA, opB, res all zero, so o_mul_a = o_mul_b = 0.
  - o_rd, o_rd_valid, o_nv, o_busy, o_done all 0.
  - Release is synchronous to i_clk. The first i_start is accepted on the first edge with i_rst_n=1.
- Cycle numbering uses the start cycle as cycle 0:
  - Operand bits k are sampled at cycles 0–31.
  - CALC is cycle 32; i_mul_res is sampled at the end of cycle 32.
  - Result bit k appears at cycle 33+k.
  - o_done coincides with bit 31 at cycle 64.
- o_busy is 0 in cycle 0 (IDLE) and 1 in cycles 1–64. The block is back in IDLE at cycle 65, where a new i_start is accepted.
- Throughput: one operation per 65 cycles.
- Reset asserted mid-operation aborts immediately. No partial o_done, and o_rd_valid drops the same instant.

## Test plan
- 1.5 × 2.0: i_rs1 = 0x3FC00000, i_rs2 = 0x40000000, real multiplier attached.
  - Serial result is 0x40400000 over cycles 33–64.
  - o_done at 64, o_nv = 0, o_busy falls at 65.
- Inf × zero: 0x7F800000 × 0x00000000 → 0x7FC00000, o_nv = 1.
- Signed infinity and signed zero:
  - 0xFF800000 × 0x40000000 → 0xFF800000, o_nv = 0.
  - 0x80000000 × 0x40000000 → 0x80000000.
- NaN handling:
  - sNaN: 0x7F800001 × 0x3F800000 → 0x7FC00000, o_nv = 1.
  - qNaN: 0x7FC00001 × 0x3F800000 → 0x7FC00000, o_nv = 0.
- Abort paths:
  - Flush: i_flush at cycle 10 → o_busy = 0 at 11. A new i_start at 11 (1.0 × 1.0) yields 0x3F800000 with no stale bits.
  - Reset: i_rst_n low at cycle 40 → all outputs 0 immediately, with no o_done.
- Start acceptance:
  - i_start held high during cycles 0–64 → exactly one operation, with no restart before 65.
  - Back-to-back i_start at cycle 65 → second result starts at cycle 98.

Source files
------------

// File: rtl/fpu_mul_serdes.sv
// fpu_mul_serdes: bit-serial operand collector and result serializer around a combinational FP32 multiplier,
// with IEEE special-case override (NaN, Inf, zero) applied to the captured product.
module fpu_mul_serdes (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic        i_rs1,
  input  logic        i_rs2,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  input  logic [31:0] i_mul_res,
  output logic        o_rd,
  output logic        o_rd_valid,
  output logic        o_nv,
  output logic        o_busy,
  output logic        o_done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] CALC  = 2'd2;
  localparam logic [1:0] SHIFT = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic        nv_q, nv_d;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic any_nan, inf_zero, sgn, spec_nv;
  logic [31:0] spec_res;
  assign a_nan    = (&opa_q[30:23]) & (|opa_q[22:0]);
  assign b_nan    = (&opb_q[30:23]) & (|opb_q[22:0]);
  assign a_snan   = a_nan & ~opa_q[22];
  assign b_snan   = b_nan & ~opb_q[22];
  assign a_inf    = (&opa_q[30:23]) & ~(|opa_q[22:0]);
  assign b_inf    = (&opb_q[30:23]) & ~(|opb_q[22:0]);
  assign a_zero   = ~(|opa_q[30:0]);
  assign b_zero   = ~(|opb_q[30:0]);
  assign sgn      = opa_q[31] ^ opb_q[31];
  assign any_nan  = a_nan | b_nan;
  assign inf_zero = (a_inf & b_zero) | (b_inf & a_zero);
  // NaN outranks Inf x zero, so nv comes from signalling-ness whenever a NaN is present
  assign spec_nv  = any_nan ? (a_snan | b_snan) : inf_zero;
  assign spec_res = (any_nan | inf_zero) ? 32'h7FC0_0000 :
                    (a_inf | b_inf)      ? {sgn, 8'hFF, 23'b0} :
                    (a_zero | b_zero)    ? {sgn, 31'b0} : i_mul_res;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    nv_d    = nv_q;
    if (i_flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      nv_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          opa_d   = {i_rs1, opa_q[31:1]};
          opb_d   = {i_rs2, opb_q[31:1]};
          cnt_d   = 5'd1;
          state_d = LOAD;
        end
        LOAD: begin
          opa_d   = {i_rs1, opa_q[31:1]};
          opb_d   = {i_rs2, opb_q[31:1]};
          cnt_d   = cnt_q + 5'd1;
          state_d = (&cnt_q) ? CALC : LOAD;
        end
        CALC: begin
          res_d   = spec_res;
          nv_d    = spec_nv;
          cnt_d   = 5'd0;
          state_d = SHIFT;
        end
        default: begin
          res_d   = res_q >> 1;
          cnt_d   = cnt_q + 5'd1;
          state_d = (&cnt_q) ? IDLE : SHIFT;
        end
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      res_q   <= 32'd0;
      nv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      nv_q    <= nv_d;
    end
  end
  assign o_mul_a    = opa_q;
  assign o_mul_b    = opb_q;
  assign o_rd_valid = state_q == SHIFT;
  assign o_rd       = o_rd_valid & res_q[0];
  assign o_nv       = nv_q;
  assign o_busy     = state_q != IDLE;
  assign o_done     = o_rd_valid & (&cnt_q) & ~i_flush;
endmodule

// File: tb/tb_fpu_mul_serdes.sv
// tb_fpu_mul_serdes: drives operands serially, attaches a behavioural FP32 multiplier and compares
// serialized results, flags and cycle timing against a reference model.
module tb_fpu_mul_serdes;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0, rs1 = 1'b0, rs2 = 1'b0;
  logic [31:0] mul_a, mul_b, mul_res;
  logic        rd, rd_valid, nv, busy, done;
  int          tests = 0, fails = 0;

  typedef struct {
    string       name;
    logic [31:0] a, b, r;
    logic        v;
  } vec_t;
  vec_t vecs[10];

  fpu_mul_serdes dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_flush(flush),
    .i_rs1(rs1), .i_rs2(rs2), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .i_mul_res(mul_res), .o_rd(rd), .o_rd_valid(rd_valid), .o_nv(nv),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  // Truncating normal-only multiplier standing in for the real datapath
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else m = p[45:23];
    if (e <= 0) return {a[31] ^ b[31], 31'b0};
    if (e >= 255) return {a[31] ^ b[31], 8'hFF, 23'b0};
    return {a[31] ^ b[31], 8'(e), m};
  endfunction

  assign mul_res = fmul(mul_a, mul_b);

  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
    bit an, bn, asn, bsn, ai, bi, az, bz, s;
    an  = a[30:23] == 8'hFF && a[22:0] != 0;
    bn  = b[30:23] == 8'hFF && b[22:0] != 0;
    asn = an && !a[22];
    bsn = bn && !b[22];
    ai  = a[30:23] == 8'hFF && a[22:0] == 0;
    bi  = b[30:23] == 8'hFF && b[22:0] == 0;
    az  = a[30:0] == 0;
    bz  = b[30:0] == 0;
    s   = a[31] ^ b[31];
    v   = 1'b0;
    if (an || bn) begin
      r = 32'h7FC00000;
      v = asn || bsn;
    end else if ((ai && bz) || (az && bi)) begin
      r = 32'h7FC00000;
      v = 1'b1;
    end else if (ai || bi) r = {s, 8'hFF, 23'b0};
    else if (az || bz) r = {s, 31'b0};
    else r = fmul(a, b);
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] m;
    int          c;
    c = $urandom_range(0, 4);
    e = c == 0 ? 8'h00 : c == 1 ? 8'hFF : 8'($urandom_range(1, 254));
    c = $urandom_range(0, 3);
    m = c == 0 ? 23'h0 : c == 1 ? {1'b0, 22'($urandom)} : c == 2 ? {1'b1, 22'($urandom)} : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // One full operation; cycle k is sampled at the negedge before inputs for cycle k are driven
  task automatic op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                    output logic [31:0] res, output logic nvv, output logic nv0, output logic terr);
    terr = 1'b0;
    res  = 32'h0;
    nvv  = 1'b0;
    nv0  = 1'b0;
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      if (busy !== (k >= 1)) terr = 1'b1;
      if (rd_valid !== (k >= 33)) terr = 1'b1;
      if (done !== (k == 64)) terr = 1'b1;
      if (k >= 33) res[k-33] = rd;
      if (k == 0) nv0 = nv;
      if (k == 64) nvv = nv;
      start = (k == 0) || hold;
      flush = 1'b0;
      rs1   = (k < 32) ? a[k] : 1'($urandom);
      rs2   = (k < 32) ? b[k] : 1'($urandom);
    end
  endtask

  task automatic run(input string n, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ev, input bit hold);
    logic [31:0] r;
    logic        v, v0, te;
    op(a, b, hold, r, v, v0, te);
    chk({n, " res"}, r, er);
    chk({n, " nv"}, 32'(v), 32'(ev));
    chk({n, " timing"}, 32'(te), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rr, r;
    logic        rv, v, v0, te;
    vecs[0] = '{"mul 1.5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0};
    vecs[1] = '{"inf x zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1};
    vecs[2] = '{"neg inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0};
    vecs[3] = '{"neg zero", 32'h80000000, 32'h40000000, 32'h80000000, 1'b0};
    vecs[4] = '{"snan", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b1};
    vecs[5] = '{"qnan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0};
    vecs[6] = '{"one x one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0};
    vecs[7] = '{"zero x inf", 32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1};
    vecs[8] = '{"negz x negz", 32'h80000000, 32'h80000000, 32'h00000000, 1'b0};
    vecs[9] = '{"neg finite", 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0};
    #1;
    chk("reset outs", 32'({busy, rd_valid, rd, nv, done}), 32'd0);
    chk("reset mul_a", mul_a, 32'd0);
    chk("reset mul_b", mul_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Vectors run back to back: each new start lands on cycle 65 of the previous one
    for (int i = 0; i < 10; i++) run(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].v, 1'b0);
    for (int i = 0; i < 40; i++) begin
      ra = rnd_fp();
      rb = rnd_fp();
      ref_mul(ra, rb, rr, rv);
      run($sformatf("rand%0d %h*%h", i, ra, rb), ra, rb, rr, rv, 1'b0);
    end
    run("held start", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b1);
    @(negedge clk);
    chk("held idle65", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("held idle66", 32'(busy), 32'd0);
    run("pre-flush snan", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      start = (k == 0);
      rs1   = k[0];
      rs2   = ~k[0];
      flush = (k == 10);
    end
    op(32'h3F800000, 32'h3F800000, 1'b0, r, v, v0, te);
    chk("flush nv clear", 32'(v0), 32'd0);
    chk("flush restart res", r, 32'h3F800000);
    chk("flush restart timing", 32'(te), 32'd0);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 0);
      rs1   = 1'($urandom);
      rs2   = 1'($urandom);
    end
    rst_n = 1'b0;
    #1;
    chk("midop reset outs", 32'({busy, rd_valid, rd, nv, done}), 32'd0);
    chk("midop reset ops", mul_a | mul_b, 32'd0);
    @(negedge clk);
    chk("reset held done", 32'({done, rd_valid}), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    run("post reset", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("final idle", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
